// File: rtl/branch_resolve_unit.sv
// In-order branch resolution: queues ID predictions, checks EX outcomes, issues flush/redirect and PHT training.
// Optional BRU_MISPREDICT_CNT_EN builds the saturating mispredict counter; otherwise mispredict_cnt is tied to 0.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CE,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    input  logic             pred_taken,
    input  logic [31:0]      pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             flush_signal,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             err_underflow
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    typedef enum logic {NORMAL, RECOVER} state_t;

    state_t      state_q, state_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;
    logic        upd_valid_q, upd_valid_d;
    logic [31:0] upd_pc_q, upd_pc_d;
    logic        upd_taken_q, upd_taken_d;
    logic        err_q, err_d;

    entry_t head;
    logic   push, pop, mispredict;

    assign pred_ready = (state_q == NORMAL) && (count_q < (PW+1)'(DEPTH));

    always_comb begin
        head       = mem_q[rd_ptr_q];
        push       = pred_valid && pred_ready && CE;
        pop        = res_valid && CE && (count_q != '0);
        mispredict = pop && ((head.taken != res_taken) ||
                             (res_taken && (head.target != res_target)));

        state_d     = state_q;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        flush_d     = 1'b0;
        redirect_d  = redirect_q;
        upd_valid_d = 1'b0;
        upd_pc_d    = upd_pc_q;
        upd_taken_d = upd_taken_q;
        err_d       = err_q;

        // RECOVER always lasts exactly one enabled cycle; a mispredict re-enters it.
        if (CE)
            state_d = mispredict ? RECOVER : NORMAL;

        if (pop) begin
            upd_valid_d = 1'b1;
            upd_pc_d    = head.pc;
            upd_taken_d = res_taken;
        end

        if (mispredict) begin
            flush_d    = 1'b1;
            redirect_d = res_taken ? res_target : head.pc + 32'd4;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: pred_pc, taken: pred_taken, target: pred_target};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end

        if (res_valid && CE && (count_q == '0))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= NORMAL;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
            err_q       <= err_d;
        end
    end

    assign flush_signal  = flush_q;
    assign redirect_pc   = redirect_q;
    assign upd_valid     = upd_valid_q;
    assign upd_pc        = upd_pc_q;
    assign upd_taken     = upd_taken_q;
    assign err_underflow = err_q;

`ifdef BRU_MISPREDICT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (mispredict && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign mispredict_cnt = cnt_q;
`else
    assign mispredict_cnt = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolution-side counterpart to the IF/ID branch predictor in the RISC-V pipeline. Each prediction issued at ID is queued in order; the actual outcome arriving from EX is checked against the oldest queued prediction. The block then produces the flush and redirect PC on a mispredict, and a one-cycle training update for the PHT. It owns recovery sequencing: wrong-path predictions are discarded and intake stalls for one cycle.

## Interface
- DEPTH, 4, in-flight prediction entries (power of two, 2..16)
- CNT_W, 16, mispredict counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- CE  in  1  pipeline clock enable; 0 freezes all state
- pred_valid  in  1  ID pushes one prediction
- pred_pc  in  32  PC of predicted branch
- pred_taken  in  1  predicted direction
- pred_target  in  32  predicted target (ignored if not taken)
- pred_ready  out  1  push accepted this cycle
- res_valid  in  1  EX resolves oldest branch (in order)
- res_taken  in  1  actual direction
- res_target  in  32  actual target
- flush_signal  out  1  one-cycle flush pulse
- redirect_pc  out  32  correct fetch PC, valid with flush_signal
- upd_valid  out  1  PHT training pulse
- upd_pc  out  32  PC being trained
- upd_taken  out  1  actual direction for training
- mispredict_cnt  out  CNT_W  saturating mispredict count
- err_underflow  out  1  sticky: res_valid with empty queue

## Operation
- Queue: circular FIFO of {pc, taken, target}, rd/wr pointers plus count (0..DEPTH).
- FSM states: NORMAL, RECOVER. Reset -> NORMAL.
- pred_ready = (state==NORMAL) && (count<DEPTH), combinational. Push occurs when pred_valid && pred_ready && CE.
- Pop occurs when res_valid && CE && count>0. Head entry is compared:
  - mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
- Correct resolution: pop; upd_valid=1, upd_pc=head.pc, upd_taken=res_taken next cycle; no flush.
- Mispredict: upd as above; flush_signal=1; redirect_pc = res_taken ? res_target : head.pc+4 (mod 2^32). The whole queue is cleared (count=0, pointers=0). A simultaneous push is dropped. FSM -> RECOVER.
- RECOVER: pred_ready=0 for exactly one CE cycle, then -> NORMAL. A res_valid in RECOVER is an underflow (queue empty).
- Simultaneous push+pop, no mispredict: both occur, count unchanged; legal at count==DEPTH only if pred_ready (it is 0 when full, so push is refused).
- Underflow: res_valid with count==0: no pop, no upd, no flush; err_underflow set, cleared only by reset.
- mispredict_cnt increments per mispredict, saturates at 2^CNT_W-1.

## Timing
- Reset values: flush_signal=0, redirect_pc=0, upd_valid=0, upd_pc=0, upd_taken=0, mispredict_cnt=0, err_underflow=0, count=0, state=NORMAL. pred_ready=1 after reset.
- flush_signal, redirect_pc, upd_* and mispredict_cnt are registered: they take effect one clk edge after the resolving cycle.
- flush_signal and upd_valid are single-cycle pulses. On any edge with CE=0, both clear to 0; all other state holds.
- Queue write is visible to pop on the following cycle (no same-cycle bypass). Resolving a branch in the cycle it is pushed is an underflow.
- Reset asserted mid-operation clears the queue and outputs immediately (asynchronous).

## Configuration
- BRU_MISPREDICT_CNT_EN: defined -> the mispredict_cnt register and its saturating incrementer are built. Undefined -> mispredict_cnt is tied to 0 and no counter logic exists; all other behaviour is identical.

## Test plan
- Push 3 predictions (pc 0x10/0x20/0x30, not taken), resolve all not taken -> 3 upd pulses, pcs 0x10,0x20,0x30; no flush; count returns to 0.
- Push pc 0x40 predicted taken to 0x80, resolve taken to 0x90 -> flush=1, redirect_pc=0x90, queue cleared, pred_ready=0 for one cycle, mispredict_cnt=1.
- Push pc 0x50 predicted taken, resolve not taken, with pred_valid asserted in the same cycle -> redirect_pc=0x54, push dropped, count=0.
- Fill DEPTH=4 entries -> pred_ready=0; then push+pop together -> pop only; next cycle pred_ready=1, count=3.
- res_valid on an empty queue -> err_underflow=1 and stays 1; no upd or flush; cleared by pulsing rst low.
- CE=0 held across a res_valid -> no pop, no pulses, count unchanged; and with BRU_MISPREDICT_CNT_EN undefined, mispredict_cnt stays 0 after mispredicts.
